// File: rtl/led_pattern_engine.sv
// ---------------------------------------------------------------------------
// led_pattern_engine
//
// Turns a host control word (okWireIn) into time-varying, PWM-dimmed,
// active-high LED patterns and reports a status word (okWireOut).
// Single clock domain (okClk), asynchronous active-low reset.
//
// Ports:
//   okClk   in   1   host interface clock
//   rst_n   in   1   async active-low reset
//   ctrl    in  32   {en[31], -, mode[25:24], speed[23:16], duty[15:8], pattern[7:0]}
//   led_on  out  8   registered LED drive, 1 = lit
//   status  out 32   {state[1:0], mode[1:0], 12'b0, step_cnt (16 bits)}
//
// Parameters:
//   TICK_DIV  okClk cycles per base tick (>= 2)
//   STEP_W    step counter width (reported zero-extended/truncated to 16)
//
// Optional build macro:
//   LED_GAMMA_EN  BREATHE brightness uses (ramp*ramp)>>8 instead of ramp.
//
// State codes on status[31:30]: IDLE=0, LOAD=1, RUN=2.
// ---------------------------------------------------------------------------
module led_pattern_engine #(
    parameter int TICK_DIV = 100800,
    parameter int STEP_W   = 16
) (
    input  logic        okClk,
    input  logic        rst_n,
    input  logic [31:0] ctrl,
    output logic [7:0]  led_on,
    output logic [31:0] status
);
    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t            state_q;
    logic [31:0]       ctrl_q;
    logic              chg_q;
    logic [PW-1:0]     presc_q;
    logic [7:0]        ival_q;      // ticks seen since the last step
    logic [STEP_W-1:0] step_cnt_q;
    logic [7:0]        rot_q;
    logic [7:0]        ramp_q;
    logic              phase_q;
    logic              dir_dn_q;    // BREATHE ramp direction, 1 = falling
    logic [7:0]        pc_q;        // free-running PWM counter
    logic [7:0]        led_on_q;

    // Control fields, always taken from the registered copy
    logic       en;
    logic [1:0] mode;
    logic [7:0] pat, duty, spd;
    assign en   = ctrl_q[31];
    assign mode = ctrl_q[25:24];
    assign spd  = ctrl_q[23:16];
    assign duty = ctrl_q[15:8];
    assign pat  = ctrl_q[7:0];

    logic       tick, step, gate;
    logic [7:0] ramp_eff, deff, led_d;

    assign tick = (presc_q == PRESC_MAX);
    assign step = tick && (ival_q == spd);   // every (S+1)-th tick

`ifdef LED_GAMMA_EN
    assign ramp_eff = 8'(({8'b0, ramp_q} * {8'b0, ramp_q}) >> 8);
`else
    assign ramp_eff = ramp_q;
`endif

    assign deff = (mode == 2'b11) ? ramp_eff : duty;
    assign gate = (pc_q < deff);

    always_comb begin
        led_d = 8'h00;
        case (mode)
            2'b00:   led_d = pat;
            2'b01:   led_d = phase_q ? pat : 8'h00;
            2'b10:   led_d = rot_q;
            default: led_d = pat;
        endcase
        if (!gate) led_d = 8'h00;
    end

    always_ff @(posedge okClk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            chg_q      <= 1'b0;
            presc_q    <= '0;
            ival_q     <= '0;
            step_cnt_q <= '0;
            rot_q      <= '0;
            ramp_q     <= '0;
            phase_q    <= 1'b0;
            dir_dn_q   <= 1'b0;
            pc_q       <= '0;
            led_on_q   <= '0;
        end else begin
            ctrl_q <= ctrl;
            chg_q  <= (ctrl != ctrl_q);   // identical rewrites never restart
            pc_q   <= pc_q + 8'd1;

            case (state_q)
                ST_IDLE: begin
                    presc_q    <= '0;
                    ival_q     <= '0;
                    step_cnt_q <= '0;
                    led_on_q   <= '0;
                    if (en) state_q <= ST_LOAD;
                end

                ST_LOAD: begin
                    presc_q    <= '0;
                    ival_q     <= '0;
                    step_cnt_q <= '0;
                    rot_q      <= pat;
                    phase_q    <= 1'b1;
                    ramp_q     <= '0;
                    dir_dn_q   <= 1'b0;
                    led_on_q   <= '0;
                    if (!en)        state_q <= ST_IDLE;
                    else if (!chg_q) state_q <= ST_RUN;
                end

                ST_RUN: begin
                    if (!en) begin
                        state_q    <= ST_IDLE;
                        presc_q    <= '0;
                        ival_q     <= '0;
                        step_cnt_q <= '0;
                        led_on_q   <= '0;
                    end else if (chg_q) begin
                        // Restart; any tick this cycle is dropped
                        state_q  <= ST_LOAD;
                        led_on_q <= '0;
                    end else begin
                        led_on_q <= led_d;
                        presc_q  <= tick ? '0 : presc_q + PW'(1);
                        if (tick) ival_q <= step ? 8'd0 : ival_q + 8'd1;
                        if (step) begin
                            step_cnt_q <= step_cnt_q + STEP_W'(1);
                            phase_q    <= ~phase_q;
                            rot_q      <= {rot_q[6:0], rot_q[7]};
                            // Ramp dwells one step at each end: 512-step period
                            if (!dir_dn_q) begin
                                if (ramp_q == 8'hFF) dir_dn_q <= 1'b1;
                                else                 ramp_q   <= ramp_q + 8'd1;
                            end else begin
                                if (ramp_q == 8'h00) dir_dn_q <= 1'b0;
                                else                 ramp_q   <= ramp_q - 8'd1;
                            end
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign led_on = led_on_q;
    assign status = {state_q, mode, 12'b0, 16'(step_cnt_q)};

endmodule

// File: tb/tb_led_pattern_engine.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_engine
//
// Drives led_pattern_engine with directed and random control words and
// compares led_on/status every cycle against a closed-form model: after a
// write latched at edge w, the sequence runs from edge w+3, the step index
// is floor(floor(j/TICK_DIV)/(S+1)) and PWM phase is (edge-1) mod 256.
// ---------------------------------------------------------------------------
module tb_led_pattern_engine;
    localparam int TD = 4;

    logic        okClk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ctrl  = '0;
    logic [7:0]  led_on;
    logic [31:0] status;

    int checks   = 0;
    int failures = 0;

    int          e;        // posedges since reset release
    logic [31:0] cfg, cfg_old;
    int          wlat, w_old;

    led_pattern_engine #(.TICK_DIV(TD), .STEP_W(16)) dut (
        .okClk (okClk),
        .rst_n (rst_n),
        .ctrl  (ctrl),
        .led_on(led_on),
        .status(status)
    );

    always #5 okClk = ~okClk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s e=%0d got=%h exp=%h", tag, e, got, exp);
        end
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
        logic [15:0] t;
        t = {x, x} << (k % 8);
        return t[15:8];
    endfunction

    function automatic int ramp_of(input int k);
        int m;
        m = k % 512;
        return (m < 256) ? m : 511 - m;
    endfunction

    function automatic logic [7:0] deff_b(input int r);
`ifdef LED_GAMMA_EN
        return 8'((r * r) >> 8);
`else
        return 8'(r);
`endif
    endfunction

    // Expected outputs after edge ee for config c latched at edge w (ee > w)
    task automatic model(input logic [31:0] c, input int w, input int ee,
                         output logic [7:0] el, output logic [31:0] es, output logic [31:0] em);
        int j, k, k2, p;
        logic [7:0] d, g;
        p  = (ee - 1) % 256;
        em = 32'hFFFF_FFFF;
        el = 8'h00;
        if (!c[31]) begin
            es = {2'b00, c[25:24], 28'b0};
        end else if (ee == w + 1) begin
            es = {2'b01, c[25:24], 28'b0};
            em = 32'hF000_0000;          // step count is stale during this cycle
        end else begin
            j  = ee - w - 3;
            k2 = ((j + 1) / TD) / (int'(c[23:16]) + 1);
            es = {2'b10, c[25:24], 12'b0, 16'(k2)};
            if (j >= 0) begin
                k = (j / TD) / (int'(c[23:16]) + 1);
                case (c[25:24])
                    2'b00:   begin d = c[15:8]; g = c[7:0]; end
                    2'b01:   begin d = c[15:8]; g = (k % 2 == 0) ? c[7:0] : 8'h00; end
                    2'b10:   begin d = c[15:8]; g = rotl(c[7:0], k); end
                    default: begin d = deff_b(ramp_of(k)); g = c[7:0]; end
                endcase
                el = (p < int'(d)) ? g : 8'h00;
            end
        end
    endtask

    task automatic run(input int n);
        logic [7:0]  el;
        logic [31:0] es, em;
        repeat (n) begin
            @(posedge okClk);
            e++;
            #1;
            if (e == wlat) begin
                model(cfg_old, w_old, e, el, es, em);
                es[29:28] = cfg[25:24];   // mode field already shows the new word
            end else begin
                model(cfg, wlat, e, el, es, em);
            end
            chk("led", {24'b0, led_on}, {24'b0, el});
            chk("status", status & em, es & em);
        end
    endtask

    // Called just after a checked edge; value is latched on the next edge
    task automatic wr(input logic [31:0] v);
        ctrl = v;
        if (v != cfg) begin
            cfg_old = cfg;
            w_old   = wlat;
            cfg     = v;
            wlat    = e + 1;
        end
    endtask

    task automatic do_reset(input logic [31:0] v);
        #2;
        rst_n = 1'b0;
        ctrl  = v;
        #1;
        chk("rst_async_led", {24'b0, led_on}, 32'h0);
        chk("rst_async_status", status, 32'h0);
        repeat (3) @(posedge okClk);
        #1;
        chk("rst_hold_led", {24'b0, led_on}, 32'h0);
        chk("rst_hold_status", status, 32'h0);
        @(negedge okClk);
        rst_n   = 1'b1;
        e       = 0;
        cfg     = '0;
        cfg_old = '0;
        wlat    = 0;
        w_old   = 0;
        wr(v);
    endtask

    initial begin
        int          cnt;
        logic [31:0] v;

        e = 0; cfg = '0; cfg_old = '0; wlat = 0; w_old = 0;

        // Reset and first release: D=FF DIRECT
        do_reset(32'h8000_FF0F);
        run(4);
        chk("release_led", {24'b0, led_on}, 32'h0F);
        run(40);

        // DIRECT at half duty: exactly 128 of 256 cycles lit
        wr(32'h8000_80AA);
        run(3);
        cnt = 0;
        repeat (256) begin
            run(1);
            if (led_on == 8'hAA) cnt++;
        end
        chk("pwm_on_cnt", cnt, 128);

        // CHASE, one step per 8 cycles
        wr(32'h8201_FF01);
        run(100);

        // BLINK, then restart with a new pattern, then an identical rewrite
        wr(32'h8100_FF0F);
        run(30);
        wr(32'h8100_FFF0);
        run(3);
        chk("restart_step", {16'b0, status[15:0]}, 32'h0);
        run(20);
        wr(32'h8100_FFF0);
        run(20);

        // Disable mid-CHASE
        wr(32'h8201_FF01);
        run(50);
        wr(32'h0201_FF01);
        run(2);
        chk("dis_state", {30'b0, status[31:30]}, 32'h0);
        chk("dis_step", {16'b0, status[15:0]}, 32'h0);
        run(10);

        // BREATHE through a full up/down period
        wr(32'h8300_00FF);
        run(2600);

        // Random control words
        repeat (30) begin
            v         = $urandom;
            v[23:16]  = 8'($urandom_range(0, 3));
            v[31]     = ($urandom_range(0, 7) != 0);
            wr(v);
            run($urandom_range(4, 400));
            if ($urandom_range(0, 3) == 0) begin
                wr(v);
                run($urandom_range(4, 60));
            end
        end

        // Reset asserted mid-run
        do_reset(32'h8000_FF0F);
        run(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/led_pattern_engine.md
Name: led_pattern_engine

Overview:
- Sits between the host control endpoint (okWireIn 32-bit control word) and the board LED open-drain mapping.
- Takes a host control word and generates time-varying active-high LED patterns: direct, blink, chase and breathe, all with PWM brightness.
- Runs in the okClk domain.
- Returns a status word for an okWireOut endpoint.

Parameters:
- TICK_DIV, 100800, okClk cycles per base tick (1 kHz at 100.8 MHz); must be ≥2.
- STEP_W, 16, width of the step counter reported in status.

Ports:
- okClk  input  1  system clock (host interface clock).
- rst_n  input  1  asynchronous active-low reset.
- ctrl  input  32  control word from wire-in. Fields:
  - [7:0] pattern
  - [15:8] duty D
  - [23:16] speed S
  - [25:24] mode
  - [31] enable
- led_on  output  8  active-high LED drive; 1 = lit. Feeds the open-drain mapping.
- status  output  32  {state[1:0], mode[1:0], 12'b0, step_cnt[STEP_W-1:0]}. Zero-extend or truncate to 16 bits if STEP_W≠16.

Behaviour:
- Reset (rst_n low, async): outputs and state are forced as follows, and are held while rst_n is low.
  - led_on=0, status=0.
  - state=IDLE.
  - All counters=0; ctrl_q=0.
- ctrl is registered into ctrl_q every cycle. chg = (ctrl != ctrl_q), registered as a one-cycle flag.
- States:
  - IDLE: entered from reset or when ctrl_q[31]=0. led_on=0; counters held at 0. Goes to LOAD when ctrl_q[31]=1.
  - LOAD: one cycle. Clears the prescaler, the step-interval counter and step_cnt. Sets rot=ctrl_q[7:0], phase=1, ramp=0, dir=up. Then goes to RUN.
  - RUN: steps the pattern. A chg flag forces LOAD. ctrl_q[31]=0 forces IDLE, with the same-cycle priority IDLE > LOAD.
- Prescaler: counts 0..TICK_DIV-1 and emits a one-cycle tick on wrap.
- Step interval: a step occurs on every (S+1)-th tick. S=0 means a step on every tick.
- step_cnt: increments on each step and wraps at 2^STEP_W-1 → 0.
- PWM: an 8-bit free-running counter pc, running in all states except reset. gate = (pc < Deff).
  - Deff=0 → never lit.
  - Deff=255 → lit 255 of 256 cycles.
- Modes in RUN (led_on is registered, one cycle after the internal signals):
  - 00 DIRECT: led_on = pattern & {8{gate}}, with Deff=D.
  - 01 BLINK: phase toggles each step. led_on = phase ? pattern & gate : 0, with Deff=D.
  - 10 CHASE: rot rotates left by 1 each step, bit7 → bit0. led_on = rot & gate, with Deff=D. pattern=0 gives all LEDs off; pattern=FF gives a static all-on.
  - 11 BREATHE: ramp moves ±1 per step.
    - Going up, at 255 dir flips and ramp stays 255 for that step. Going down, at 0 dir flips and ramp stays 0.
    - Full period is 512 steps.
    - led_on = pattern & gate, with Deff=ramp.
- Latency: a ctrl change in cycle N reaches led_on by cycle N+4, at the first PWM-gated output after LOAD.
- Simultaneous tick and LOAD: LOAD wins; that tick is discarded.
- A host write mid-sequence always restarts the sequence. A rewrite of an identical value is not a change and does not restart.

Optional Feature:
- Macro: LED_GAMMA_EN.
- Defined: in BREATHE mode only, Deff = (ramp*ramp)>>8, an 8-bit result with ramp=255 giving 254, for perceptually linear fading.
- Not defined: Deff = ramp (linear).
- Other modes are unaffected either way.

Test Plan:
- Common setup: TICK_DIV=4 in every scenario.
- Reset: rst_n=0 with ctrl=0x8000FF0F asserted mid-run → led_on=0 and status=0 immediately (async). After release, led_on=0x0F within 4 cycles (D=FF gated).
- DIRECT/PWM: ctrl=0x8000_80AA → over 256 cycles, led_on=0xAA for exactly 128 cycles and 0x00 for 128.
- CHASE: ctrl=0x8201_FF01 → rot steps every 8 cycles (S=1): 0x01, 0x02 … 0x80, then 0x01; step_cnt increments at the same rate.
- BLINK + restart: ctrl=0x8100_FF0F → led_on toggles 0x0F/0x00 every 4 cycles. Change to 0x8100_FFF0 → step_cnt=0 and led_on=0xF0 by cycle N+4.
- BREATHE: ctrl=0x8300_00FF → ramp climbs 0 → 255 in 255 steps, then descends. With LED_GAMMA_EN, at ramp=128 led_on is lit 64 of 256 cycles; without the macro, 128 of 256.
- Disable: clear bit31 mid-CHASE → next cycle state=IDLE, led_on=0, status[31:30]=IDLE code, counters=0.
